// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide unit with HI/LO registers.
// multu: 32-cycle radix-2 shift-add into a 64-bit accumulator.
// divu:  32-cycle restoring shift-subtract; remainder in acc[63:32],
//        quotient in acc[31:0]. Both leave HI/LO in the same accumulator
//        halves, so the writeback is shared.
// Timeline: accept edge E, RUN edges E+1..E+32, WB edge E+33 loads HI/LO.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        rd_req,
  input  logic        rd_hi,
  input  logic        wr_req,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StRun, StWb} state_t;

  localparam logic OpMultu = 1'b0;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [63:0] r_acc;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  logic [32:0] w_mul_sum;
  logic [32:0] w_div_shift;
  logic [32:0] w_div_diff;
  logic        w_div_ge;
  logic [63:0] w_acc_next;
  logic        w_busy;

  // One radix-2 iteration of the selected operation.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_a} : 33'd0);
    w_div_shift = {r_acc[63:32], r_acc[31]};
    // A zero divisor always compares as "fits", giving an all-ones quotient
    // and a remainder that accumulates the dividend bit by bit.
    w_div_ge    = (w_div_shift >= {1'b0, r_b});
    w_div_diff  = w_div_shift - {1'b0, r_b};
    w_acc_next  = r_acc;
    if (r_op == OpMultu) begin
      w_acc_next = {w_mul_sum, r_acc[31:1]};
    end else if (w_div_ge) begin
      w_acc_next = {w_div_diff[31:0], r_acc[30:0], 1'b1};
    end else begin
      w_acc_next = {w_div_shift[31:0], r_acc[30:0], 1'b0};
    end
  end

  // Status and pipeline hold request.
  always_comb begin
    w_busy = (r_state != StIdle);
    busy   = w_busy;
    stall  = (w_busy & (start | rd_req | wr_req)) | (start & wr_req);
    rdata  = rd_hi ? r_hi : r_lo;
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign done = r_done;

  // Control FSM, datapath registers and HI/LO updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= 5'd0;
      r_op    <= 1'b0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_acc   <= 64'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            // start wins over a simultaneous write; the writer sees stall.
            r_op    <= op;
            r_a     <= srca;
            r_b     <= srcb;
            r_acc   <= {32'd0, (op == OpMultu) ? srcb : srca};
            r_cnt   <= 5'd0;
            r_state <= StRun;
          end else if (wr_req) begin
            if (wr_hi) begin
              r_hi <= wdata;
            end else begin
              r_lo <= wdata;
            end
          end
        end
        StRun: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= StWb;
          end
        end
        StWb: begin
          r_hi    <= r_acc[63:32];
          r_lo    <= r_acc[31:0];
          r_done  <= 1'b1;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: reset, multu/divu results and timing,
// read/write stalls, start-while-busy, and reset abort.
module tb_muldiv_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        rd_req;
  logic        rd_hi;
  logic        wr_req;
  logic        wr_hi;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;

  int checks;
  int fails;

  muldiv_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .srca   (srca),
    .srcb   (srcb),
    .rd_req (rd_req),
    .rd_hi  (rd_hi),
    .wr_req (wr_req),
    .wr_hi  (wr_hi),
    .wdata  (wdata),
    .rdata  (rdata),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .stall  (stall),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait (bounded) until the unit is idle again.
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    start = 1'b1; op = o; srca = a; srcb = b;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (rdata !== 32'd0) begin fails++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin
      fails++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi, lo);
    end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
  endtask

  task automatic test_multu_max();
    start = 1'b1; op = 1'b0; srca = 32'hFFFF_FFFF; srcb = 32'hFFFF_FFFF;
    #1;
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL mul_idle_stall: got %b want 0", stall); end
    tick();  // accept edge E
    start = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      checks++; if (busy !== 1'b1 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
        fails++;
        $display("FAIL mul_run_cycle%0d: busy=%b done=%b hi=%h lo=%h want 1 0 0 0",
                 i, busy, done, hi, lo);
      end
      tick();
    end
    // WB cycle: still busy, HI/LO still old
    checks++; if (busy !== 1'b1 || hi !== 32'd0 || lo !== 32'd0) begin
      fails++; $display("FAIL mul_wb_cycle: busy=%b hi=%h lo=%h want 1 0 0", busy, hi, lo);
    end
    tick();  // E+33
    checks++; if (hi !== 32'hFFFF_FFFE) begin fails++; $display("FAIL mul_hi: got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin fails++; $display("FAIL mul_lo: got %h want 00000001", lo); end
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin
      fails++; $display("FAIL mul_done: busy=%b done=%b want 0 1", busy, done);
    end
    tick();
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL mul_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_divu();
    int n;
    run_op(1'b1, 32'd100, 32'd7, n);
    checks++; if (n !== 33) begin fails++; $display("FAIL div_cycles: got %0d want 33", n); end
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin
      fails++; $display("FAIL div_100_7: got lo=%h hi=%h want 0000000e 00000002", lo, hi);
    end
    run_op(1'b1, 32'h0000_1234, 32'd0, n);
    checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'h0000_1234) begin
      fails++; $display("FAIL div_by_zero: got lo=%h hi=%h want ffffffff 00001234", lo, hi);
    end
    run_op(1'b1, 32'hFFFF_FFFF, 32'd1, n);
    checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'd0) begin
      fails++; $display("FAIL div_max_1: got lo=%h hi=%h want ffffffff 00000000", lo, hi);
    end
    run_op(1'b1, 32'd5, 32'd10, n);
    checks++; if (lo !== 32'd0 || hi !== 32'd5) begin
      fails++; $display("FAIL div_5_10: got lo=%h hi=%h want 00000000 00000005", lo, hi);
    end
  endtask

  task automatic test_read_stall();
    int n;
    // HI=5, LO=0 left by the previous divide
    start = 1'b1; op = 1'b0; srca = 32'd3; srcb = 32'd5;
    tick();
    start = 1'b0;
    rd_req = 1'b1; rd_hi = 1'b1;
    #1;
    n = 0;
    while (stall && n < 100) begin
      checks++; if (rdata !== 32'd5) begin
        fails++; $display("FAIL rd_old_hi_cycle%0d: got %h want 00000005", n, rdata);
      end
      tick();
      n++;
    end
    checks++; if (n !== 33) begin fails++; $display("FAIL rd_stall_cycles: got %0d want 33", n); end
    checks++; if (rdata !== 32'd0) begin fails++; $display("FAIL rd_mfhi: got %h want 0", rdata); end
    rd_hi = 1'b0;
    #1;
    checks++; if (rdata !== 32'd15 || stall !== 1'b0) begin
      fails++; $display("FAIL rd_mflo: got rdata=%h stall=%b want 0000000f 0", rdata, stall);
    end
    rd_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    start = 1'b1; op = 1'b0; srca = 32'd7; srcb = 32'd6;
    tick();  // first op accepted
    op = 1'b1; srca = 32'd100; srcb = 32'd7;  // held second request
    #1;
    checks++; if (stall !== 1'b1) begin fails++; $display("FAIL b2b_stall: got %b want 1", stall); end
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    checks++; if (n !== 33) begin fails++; $display("FAIL b2b_first_cycles: got %0d want 33", n); end
    checks++; if (lo !== 32'd42 || hi !== 32'd0) begin
      fails++; $display("FAIL b2b_first_result: got lo=%h hi=%h want 0000002a 0", lo, hi);
    end
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL b2b_idle_stall: got %b want 0", stall); end
    tick();  // second op accepted
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    checks++; if (n !== 33) begin fails++; $display("FAIL b2b_second_cycles: got %0d want 33", n); end
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin
      fails++; $display("FAIL b2b_second_result: got lo=%h hi=%h want 0000000e 00000002", lo, hi);
    end
  endtask

  task automatic test_write();
    int n;
    wr_req = 1'b1; wr_hi = 1'b0; wdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL wr_idle_stall: got %b want 0", stall); end
    tick();
    checks++; if (lo !== 32'hDEAD_BEEF || hi !== 32'd2) begin
      fails++; $display("FAIL wr_mtlo: got lo=%h hi=%h want deadbeef 00000002", lo, hi);
    end
    wr_hi = 1'b1; wdata = 32'h0000_55AA;
    tick();
    checks++; if (hi !== 32'h0000_55AA || lo !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL wr_mthi: got hi=%h lo=%h want 000055aa deadbeef", hi, lo);
    end
    start = 1'b1; op = 1'b0; srca = 32'd2; srcb = 32'd3;
    wr_hi = 1'b1; wdata = 32'h0000_0077;
    #1;
    checks++; if (stall !== 1'b1) begin fails++; $display("FAIL wr_start_stall: got %b want 1", stall); end
    tick();
    start = 1'b0;
    #1;
    checks++; if (busy !== 1'b1 || hi !== 32'h0000_55AA) begin
      fails++; $display("FAIL wr_dropped: busy=%b hi=%h want 1 000055aa", busy, hi);
    end
    n = 0;
    while (stall && n < 100) begin
      tick();
      n++;
    end
    checks++; if (n !== 33 || hi !== 32'd0 || lo !== 32'd6) begin
      fails++; $display("FAIL wr_retry_wait: n=%0d hi=%h lo=%h want 33 0 00000006", n, hi, lo);
    end
    tick();
    checks++; if (hi !== 32'h0000_0077 || lo !== 32'd6) begin
      fails++; $display("FAIL wr_retry_applied: hi=%h lo=%h want 00000077 00000006", hi, lo);
    end
    wr_req = 1'b0;
  endtask

  task automatic test_reset_abort();
    int  n;
    logic seen_done;
    start = 1'b1; op = 1'b0; srca = 32'd7; srcb = 32'd9;
    tick();
    start = 1'b0;
    repeat (10) tick();  // cnt = 10
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin
      fails++; $display("FAIL abort_state: busy=%b hi=%h lo=%h done=%b want 0 0 0 0",
                        busy, hi, lo, done);
    end
    seen_done = 1'b0;
    repeat (40) begin
      if (done) seen_done = 1'b1;
      tick();
    end
    checks++; if (seen_done !== 1'b0 || lo !== 32'd0) begin
      fails++; $display("FAIL abort_no_done: done_seen=%b lo=%h want 0 0", seen_done, lo);
    end
    run_op(1'b0, 32'd7, 32'd9, n);
    checks++; if (n !== 33 || lo !== 32'd63 || hi !== 32'd0 || done !== 1'b1) begin
      fails++; $display("FAIL abort_rerun: n=%0d lo=%h hi=%h done=%b want 33 0000003f 0 1",
                        n, lo, hi, done);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset = 1'b0; start = 1'b0; op = 1'b0; srca = 32'd0; srcb = 32'd0;
    rd_req = 1'b0; rd_hi = 1'b0; wr_req = 1'b0; wr_hi = 1'b0; wdata = 32'd0;
    test_reset();
    test_multu_max();
    test_divu();
    test_read_stall();
    test_back_to_back();
    test_write();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The module SHALL have `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The module SHALL have `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 The module SHALL have `start`, input, 1 bit: request to begin the operation given by `op` on `srca`/`srcb`.
REQ-004 The module SHALL have `op`, input, 1 bit: 0 = multu (unsigned multiply), 1 = divu (unsigned divide).
REQ-005 The module SHALL have `srca` and `srcb`, inputs, 32 bits each: operands; srca is the multiplicand or dividend, srcb the multiplier or divisor.
REQ-006 The module SHALL have `rd_req`, input, 1 bit: mfhi/mflo read request; and `rd_hi`, input, 1 bit: 1 = read HI, 0 = read LO.
REQ-007 The module SHALL have `wr_req`, input, 1 bit: mthi/mtlo write request; `wr_hi`, input, 1 bit: 1 = write HI, 0 = write LO; and `wdata`, input, 32 bits: write data.
REQ-008 The module SHALL have `rdata`, output, 32 bits: HI when `rd_hi`=1, otherwise LO; combinational.
REQ-009 The module SHALL have `hi` and `lo`, outputs, 32 bits each: current HI/LO register contents.
REQ-010 The module SHALL have `busy`, output, 1 bit: high when the state is not IDLE.
REQ-011 The module SHALL have `stall`, output, 1 bit: combinational pipeline hold request.
REQ-012 The module SHALL have `done`, output, 1 bit: registered one-cycle completion pulse.

Function
REQ-013 The module SHALL have three states: IDLE, RUN and WB, plus a 5-bit iteration counter `cnt`.
REQ-014 In IDLE, at a rising edge with `start`=1, the module SHALL accept the request: latch `op`, `srca` and `srcb`, clear `cnt`, and go to RUN.
REQ-015 In RUN, each rising edge SHALL perform one radix-2 iteration and increment `cnt`; the edge with `cnt`=31 SHALL go to WB, so RUN always lasts exactly 32 cycles.
REQ-016 multu SHALL use shift-add on a 64-bit product; the result SHALL be HI = product[63:32], LO = product[31:0], modulo 2^64 with no overflow flag.
REQ-017 divu SHALL use restoring shift-subtract; the result SHALL be LO = quotient, HI = remainder.
REQ-018 divu with srcb = 0 SHALL yield LO = 32'hFFFFFFFF and HI = srca, with no exception.
REQ-019 The WB edge SHALL load HI and LO together, return to IDLE, and set `done`=1 for exactly the following cycle.
REQ-020 If the accept edge is E, HI/LO SHALL change at edge E+33 and at no edge between E+1 and E+32.
REQ-021 `stall` SHALL equal `busy` & (`start` | `rd_req` | `wr_req`), OR'd with (`start` & `wr_req`).
REQ-022 A requester SHALL hold its request until `stall`=0; a request is taken at the first rising edge with `stall`=0.
REQ-023 `start` while busy SHALL be ignored and SHALL NOT disturb the operation in progress or the latched operands.
REQ-024 In IDLE with `start`=1 and `wr_req`=1 together, `start` SHALL be accepted and the write dropped for that cycle, with `stall`=1.
REQ-025 In IDLE with `wr_req`=1 and `start`=0, the module SHALL write `wdata` to HI or LO per `wr_hi` at the edge, leaving the other register unchanged.
REQ-026 `rdata` SHALL reflect HI/LO as of the last edge; during RUN and WB it SHALL show the old values, with `stall` high whenever `rd_req`=1.
REQ-027 Operand inputs SHALL be ignored after the accept edge until the next accept.

Reset
REQ-028 When `reset`=1 at a rising edge, the module SHALL set state to IDLE, `cnt`=0, HI=0, LO=0 and `done`=0, and clear internal operand and accumulator registers.
REQ-029 Reset SHALL take priority over `start`, `wr_req` and any operation in progress; a reset mid-RUN or in WB SHALL abort with no HI/LO update.
REQ-030 After reset, `busy`=0, `stall`=0 and `rdata`=0.

Verification
REQ-031 multu, srca=0xFFFFFFFF, srcb=0xFFFFFFFF -> at E+33 HI=0xFFFFFFFE, LO=0x00000001; `done` high for one cycle; `busy` high for 33 cycles.
REQ-032 divu, srca=100, srcb=7 -> LO=14, HI=2; divu, srca=0x1234, srcb=0 -> LO=0xFFFFFFFF, HI=0x00001234.
REQ-033 mfhi (`rd_req`=1, `rd_hi`=1) asserted 1 cycle after a multu 3*5 start -> `stall`=1 through the WB cycle, then `rdata`=0 (HI) with `stall`=0; mflo then reads 15.
REQ-034 A second `start` held during RUN with different operands -> ignored while busy; first result intact; second op accepted at the first IDLE edge and completes 33 edges later.
REQ-035 mtlo 0xDEADBEEF in IDLE -> LO=0xDEADBEEF, HI unchanged; `start` and `wr_req` together -> multiply accepted, write retried and applied after completion.
REQ-036 `reset` pulsed at RUN cnt=10 of multu 7*9 -> next cycle IDLE, HI=LO=0, `done` never asserted, and a subsequent multu 7*9 yields LO=63.
